// File: rtl/seg_src_arb.sv
// Round-robin display-source arbiter: grants one of three display bundles for a fixed
// dwell period, with rising-edge preemption by the urgent source 0.
module seg_src_arb #(
  parameter int unsigned DWELL_CNT = 50_000_000,
  parameter int unsigned CNT_W     = 26
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [2:0]        req,
  input  logic [19:0]       data0,
  input  logic [19:0]       data1,
  input  logic [19:0]       data2,
  input  logic [5:0]        point0,
  input  logic [5:0]        point1,
  input  logic [5:0]        point2,
  input  logic              sign0,
  input  logic              sign1,
  input  logic              sign2,
  input  logic              seg_en0,
  input  logic              seg_en1,
  input  logic              seg_en2,
  output logic [19:0]       data,
  output logic [5:0]        point,
  output logic              sign,
  output logic              seg_en,
  output logic [2:0]        grant,
  output logic              busy
);

  typedef enum logic {StIdle, StHold} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL_CNT - 1);

  state_e           state_q, state_d;
  logic [1:0]       g_q, g_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req0_q;
  logic [19:0]      data_q, data_d;
  logic [5:0]       point_q, point_d;
  logic             sign_q, sign_d;
  logic             seg_en_q, seg_en_d;
  logic [2:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [1:0]       pick;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
    logic b;
    case (i)
      2'd0:    b = r[0];
      2'd1:    b = r[1];
      default: b = r[2];
    endcase
    return b;
  endfunction

  // Scan ptr+1, ptr+2, then ptr itself so the last holder is considered last.
  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
    logic [1:0] n1;
    logic [1:0] n2;
    logic [1:0] res;
    n1 = nxt(p);
    n2 = nxt(n1);
    if (req_at(r, n1))      res = n1;
    else if (req_at(r, n2)) res = n2;
    else                    res = p;
    return res;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    logic [2:0] o;
    case (i)
      2'd0:    o = 3'b001;
      2'd1:    o = 3'b010;
      default: o = 3'b100;
    endcase
    return o;
  endfunction

  assign pick = rr_pick(ptr_q, req);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req != 3'b000) begin
          state_d = StHold;
          g_d     = pick;
          ptr_d   = pick;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (req == 3'b000) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (!req_at(req, g_q)) begin
          g_d   = pick;
          ptr_d = pick;
          cnt_d = '0;
        end else if (req[0] && !req0_q && (g_q != 2'd0)) begin
          g_d   = 2'd0;
          ptr_d = 2'd0;
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          g_d   = pick;
          ptr_d = pick;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Grant follows the new state directly; the bundle is one cycle behind it.
  always_comb begin
    grant_d  = (state_d == StHold) ? onehot(g_d) : 3'b000;
    busy_d   = (state_d == StHold);
    data_d   = '0;
    point_d  = '0;
    sign_d   = 1'b0;
    seg_en_d = 1'b0;
    if (state_q == StHold) begin
      case (g_q)
        2'd0: begin
          data_d   = data0;
          point_d  = point0;
          sign_d   = sign0;
          seg_en_d = seg_en0;
        end
        2'd1: begin
          data_d   = data1;
          point_d  = point1;
          sign_d   = sign1;
          seg_en_d = seg_en1;
        end
        default: begin
          data_d   = data2;
          point_d  = point2;
          sign_d   = sign2;
          seg_en_d = seg_en2;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      g_q      <= 2'd0;
      ptr_q    <= 2'd2;
      cnt_q    <= '0;
      req0_q   <= 1'b0;
      data_q   <= '0;
      point_q  <= '0;
      sign_q   <= 1'b0;
      seg_en_q <= 1'b0;
      grant_q  <= 3'b000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      req0_q   <= req[0];
      data_q   <= data_d;
      point_q  <= point_d;
      sign_q   <= sign_d;
      seg_en_q <= seg_en_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
    end
  end

  assign data   = data_q;
  assign point  = point_q;
  assign sign   = sign_q;
  assign seg_en = seg_en_q;
  assign grant  = grant_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_seg_src_arb.sv
// Bench for seg_src_arb: cycle-by-cycle reference model plus directed scenarios with
// hand-computed grant/data expectations.
module tb_seg_src_arb;

  localparam int DW = 8;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [19:0] d_in [3];
  logic [5:0]  p_in [3];
  logic        s_in [3];
  logic        e_in [3];
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [2:0]  grant;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  seg_src_arb #(.DWELL_CNT(DW), .CNT_W(CW)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .req(req),
    .data0(d_in[0]), .data1(d_in[1]), .data2(d_in[2]),
    .point0(p_in[0]), .point1(p_in[1]), .point2(p_in[2]),
    .sign0(s_in[0]), .sign1(s_in[1]), .sign2(s_in[2]),
    .seg_en0(e_in[0]), .seg_en1(e_in[1]), .seg_en2(e_in[2]),
    .data(data), .point(point), .sign(sign), .seg_en(seg_en),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: holder is -1 when nobody holds the display.
  int          m_hold = -1;
  int          m_last = 2;
  int          m_cnt  = 0;
  bit          m_prev0 = 1'b0;
  bit          m_valid = 1'b0;
  logic [19:0] e_data = '0;
  logic [5:0]  e_point = '0;
  logic        e_sign = 1'b0;
  logic        e_en = 1'b0;
  logic [2:0]  e_grant = '0;
  logic        e_busy = 1'b0;

  function automatic int rr(input int last, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hold = -1; m_last = 2; m_cnt = 0; m_prev0 = 1'b0; m_valid = 1'b1;
      e_data = '0; e_point = '0; e_sign = 1'b0; e_en = 1'b0;
    end else begin
      if (m_hold >= 0) begin
        e_data = d_in[m_hold]; e_point = p_in[m_hold];
        e_sign = s_in[m_hold]; e_en = e_in[m_hold];
      end else begin
        e_data = '0; e_point = '0; e_sign = 1'b0; e_en = 1'b0;
      end
      if (req == 3'b000) begin
        m_hold = -1; m_cnt = 0;
      end else if (m_hold < 0 || !req[m_hold]) begin
        m_hold = rr(m_last, req); m_last = m_hold; m_cnt = 0;
      end else if (req[0] && !m_prev0 && m_hold != 0) begin
        m_hold = 0; m_last = 0; m_cnt = 0;
      end else if (m_cnt == DW - 1) begin
        m_hold = rr(m_last, req); m_last = m_hold; m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_prev0 = req[0];
    end
    e_grant = (m_hold >= 0) ? (3'b001 << m_hold) : 3'b000;
    e_busy  = (m_hold >= 0);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_data", 32'(data), 32'(e_data));
      check("m_point", 32'(point), 32'(e_point));
      check("m_sign", 32'(sign), 32'(e_sign));
      check("m_seg_en", 32'(seg_en), 32'(e_en));
      check("m_grant", 32'(grant), 32'(e_grant));
      check("m_busy", 32'(busy), 32'(e_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [2:0] r);
    rst_n = 1'b0;
    req   = r;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    d_in[0] = 20'hAAAAA; p_in[0] = 6'h01; s_in[0] = 1'b1; e_in[0] = 1'b1;
    d_in[1] = 20'h11111; p_in[1] = 6'h02; s_in[1] = 1'b0; e_in[1] = 1'b1;
    d_in[2] = 20'h22222; p_in[2] = 6'h04; s_in[2] = 1'b1; e_in[2] = 1'b1;

    // 1. Reset with all requesting
    req = 3'b111;
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_seg_en", 32'(seg_en), 32'h0);
    rst_n = 1'b1;
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_data_lag", 32'(data), 32'h0);
    tick();
    check("t1_data", 32'(data), 32'hAAAAA);
    check("t1_point", 32'(point), 32'h01);
    check("t1_sign", 32'(sign), 32'h1);

    // 2. Rotation between sources 1 and 2
    do_reset(3'b110);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_g1", 32'(grant), 32'h2);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_g2", 32'(grant), 32'h4);
      if (i == 0) check("t2_data_lag", 32'(data), 32'h11111);
      if (i == 1) check("t2_data2", 32'(data), 32'h22222);
    end
    tick();
    check("t2_back", 32'(grant), 32'h2);

    // 3. Sole requester with live data changes
    do_reset(3'b010);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_sole", 32'(grant), 32'h2);
    end
    d_in[1] = 20'h12345;
    tick();
    check("t3_d_a", 32'(data), 32'h12345);
    d_in[1] = 20'h00001;
    check("t3_d_hold", 32'(data), 32'h12345);
    tick();
    check("t3_d_b", 32'(data), 32'h00001);

    // 4. Preemption of source 2 at cnt=3
    do_reset(3'b100);
    tick();
    check("t4_g2", 32'(grant), 32'h4);
    repeat (3) tick();
    req = 3'b111;
    tick();
    check("t4_pre", 32'(grant), 32'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t4_g0", 32'(grant), 32'h1);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t4_g1", 32'(grant), 32'h2);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t4_g2b", 32'(grant), 32'h4);
    end
    tick();
    check("t4_g0b", 32'(grant), 32'h1);

    // 5. Holder drop restarts the dwell, then release
    do_reset(3'b010);
    repeat (4) tick();
    check("t5_g1", 32'(grant), 32'h2);
    req = 3'b100;
    tick();
    check("t5_drop", 32'(grant), 32'h4);
    req = 3'b110;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t5_dwell", 32'(grant), 32'h4);
    end
    tick();
    check("t5_rot", 32'(grant), 32'h2);
    req = 3'b000;
    tick();
    check("t5_rel_grant", 32'(grant), 32'h0);
    check("t5_rel_busy", 32'(busy), 32'h0);
    check("t5_rel_en_lag", 32'(seg_en), 32'h1);
    tick();
    check("t5_rel_en", 32'(seg_en), 32'h0);
    check("t5_rel_data", 32'(data), 32'h0);

    // 6. Reset pulse during HOLD
    do_reset(3'b100);
    repeat (3) tick();
    check("t6_g2", 32'(grant), 32'h4);
    rst_n = 1'b0;
    tick();
    check("t6_grant", 32'(grant), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_data", 32'(data), 32'h0);
    check("t6_en", 32'(seg_en), 32'h0);
    rst_n = 1'b1;
    req   = 3'b110;
    tick();
    check("t6_first", 32'(grant), 32'h2);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
